// File: rtl/skipring_mc.sv
// skipring_mc: multi-channel pulse-skipping ring producing CH fractional-rate clock enables
//   iCLK     sole clock, rising edge
//   RST      synchronous active-high reset
//   E        advance enable (effective advance = E & RUN & ~LD)
//   LD       load pulse: selector <= rSEL, position <= 0, restart ring
//   rSEL     selector pattern loaded by LD
//   MODE     0 = free-running, 1 = one-shot (stop after a wrap)
//   MASK_WR  strobe writing MASK into the shadow mask register
//   MASK     channel c mask = MASK[c*LEN +: LEN]
//   oEN      registered per-channel enable pulses
//   oB0      selector bit 0
//   oWRAP    registered one-cycle pulse at each revolution end
//   oPEND    shadow mask waiting for a wrap
//   oRUN     ring is running
module skipring_mc #(
   parameter int LEN = 16,
   parameter int CH = 2,
   parameter logic [LEN-1:0] defSEL = {{(LEN-1){1'b0}}, 1'b1},
   parameter logic [CH*LEN-1:0] defMASK = '0
) (
   input  logic              iCLK,
   input  logic              RST,
   input  logic              E,
   input  logic              LD,
   input  logic [LEN-1:0]    rSEL,
   input  logic              MODE,
   input  logic              MASK_WR,
   input  logic [CH*LEN-1:0] MASK,
   output logic [CH-1:0]     oEN,
   output logic              oB0,
   output logic              oWRAP,
   output logic              oPEND,
   output logic              oRUN
);
   localparam int PW = $clog2(LEN);
   logic [LEN-1:0]    sel_q, sel_d;
   logic [PW-1:0]     pos_q, pos_d;
   logic [CH*LEN-1:0] act_q, act_d, shd_q, shd_d;
   logic              pend_q, pend_d, run_q, run_d, wrap_q;
   logic [CH-1:0]     en_q, en_d;
   logic              adv, last, wrap, tcond;
   always_comb begin
      adv   = E & run_q & ~LD;
      last  = pos_q == PW'(LEN - 1);
      wrap  = adv & last;
      // a stopped ring has no wrap to wait for, so staged masks apply at once
      tcond = wrap | ~run_q;
      en_d  = '0;
      for (int c = 0; c < CH; c++) en_d[c] = adv & |(sel_q & act_q[c*LEN +: LEN]);
      sel_d  = LD ? rSEL : adv ? {sel_q[LEN-2:0], sel_q[LEN-1]} : sel_q;
      pos_d  = LD ? '0 : adv ? (last ? '0 : pos_q + PW'(1)) : pos_q;
      run_d  = LD | (run_q & ~(wrap & MODE));
      shd_d  = (MASK_WR & ~tcond) ? MASK : shd_q;
      // a write landing on the transfer edge bypasses the shadow: newest value wins
      act_d  = (MASK_WR & tcond) ? MASK : (pend_q & tcond) ? shd_q : act_q;
      pend_d = MASK_WR ? ~tcond : pend_q & ~tcond;
   end
   always_ff @(posedge iCLK) begin
      if (RST) begin
         sel_q  <= defSEL;
         pos_q  <= '0;
         act_q  <= defMASK;
         shd_q  <= '0;
         pend_q <= 1'b0;
         run_q  <= 1'b1;
         en_q   <= '0;
         wrap_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         pos_q  <= pos_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         run_q  <= run_d;
         en_q   <= en_d;
         wrap_q <= wrap;
      end
   end
   assign oEN   = en_q;
   assign oB0   = sel_q[0];
   assign oWRAP = wrap_q;
   assign oPEND = pend_q;
   assign oRUN  = run_q;
endmodule

// File: tb/tb_skipring_mc.sv
// tb_skipring_mc: scoreboard bench for skipring_mc against a position-based reference model
module tb_skipring_mc;
   localparam int LEN = 16;
   localparam int CH = 2;
   localparam logic [CH*LEN-1:0] M_FREE = {16'hFFFF, 16'b0011010001000101};
   localparam logic [CH*LEN-1:0] M_DEF  = {16'hFFFF, 16'h0001};
   logic clk = 1'b0;
   logic rst, e, ld, mode, mwr;
   logic [LEN-1:0] rsel;
   logic [CH*LEN-1:0] mask;
   logic [CH-1:0] en;
   logic b0, wrap, pend, run;
   always #5 clk = ~clk;
   skipring_mc #(.LEN(LEN), .CH(CH)) dut (
      .iCLK(clk), .RST(rst), .E(e), .LD(ld), .rSEL(rsel), .MODE(mode),
      .MASK_WR(mwr), .MASK(mask), .oEN(en), .oB0(b0), .oWRAP(wrap),
      .oPEND(pend), .oRUN(run)
   );
   typedef struct packed {
      logic [CH-1:0] en;
      logic wrap, b0, pend, run;
   } exp_t;
   exp_t q[$];
   int n_cmp = 0, n_bad = 0;
   // model: selector is the loaded base pattern rotated by the ring position
   logic [LEN-1:0] m_base;
   int m_pos;
   logic [LEN-1:0] m_act[CH];
   logic [LEN-1:0] m_shd[CH];
   bit m_pend, m_run;
   function automatic logic [LEN-1:0] rotl(input logic [LEN-1:0] p, input int n);
      return (p << n) | (p >> (LEN - n));
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("oEN", 32'(en), 32'(x.en));
         chk("oWRAP", 32'(wrap), 32'(x.wrap));
         chk("oB0", 32'(b0), 32'(x.b0));
         chk("oPEND", 32'(pend), 32'(x.pend));
         chk("oRUN", 32'(run), 32'(x.run));
      end
   end
   task automatic step(input bit r, input bit ei, input bit li, input logic [LEN-1:0] rs,
                       input bit mo, input bit mw, input logic [CH*LEN-1:0] mk);
      exp_t x;
      bit adv, wr, tc;
      logic [LEN-1:0] s;
      rst = r; e = ei; ld = li; rsel = rs; mode = mo; mwr = mw; mask = mk;
      x = '0;
      if (r) begin
         m_base = 1; m_pos = 0; m_pend = 0; m_run = 1;
         for (int c = 0; c < CH; c++) begin m_act[c] = 0; m_shd[c] = 0; end
      end else begin
         s = rotl(m_base, m_pos);
         adv = ei && m_run && !li;
         wr = adv && m_pos == LEN - 1;
         for (int c = 0; c < CH; c++) x.en[c] = adv && ((s & m_act[c]) != 0);
         x.wrap = wr;
         tc = wr || !m_run;
         for (int c = 0; c < CH; c++) begin
            if (mw && tc) m_act[c] = mk[c*LEN +: LEN];
            else if (mw) m_shd[c] = mk[c*LEN +: LEN];
            else if (m_pend && tc) m_act[c] = m_shd[c];
         end
         m_pend = mw ? !tc : (m_pend && !tc);
         if (li) begin m_base = rs; m_pos = 0; m_run = 1; end
         else if (adv) begin
            m_pos = (m_pos + 1) % LEN;
            if (wr && mo) m_run = 0;
         end
      end
      s = rotl(m_base, m_pos);
      x.b0 = s[0]; x.pend = m_pend; x.run = m_run;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask
   task automatic run_n(input int n, input bit mo, output int c0, output int c1, output int cw);
      c0 = 0; c1 = 0; cw = 0;
      repeat (n) begin
         step(0, 1, 0, 0, mo, 0, 0);
         c0 += int'(en[0]); c1 += int'(en[1]); cw += int'(wrap);
      end
   endtask
   initial begin
      int c0, c1, cw;
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, M_FREE);
      chk("pend_after_write", 32'(pend), 1);
      run_n(15, 0, c0, c1, cw);
      chk("first_wrap_pend", 32'(pend), 0);
      run_n(16, 0, c0, c1, cw);
      chk("free_ch0_pulses", c0, 6);
      chk("free_ch1_pulses", c1, 16);
      chk("free_wraps", cw, 1);
      run_n(5, 0, c0, c1, cw);
      step(0, 1, 0, 0, 0, 1, M_DEF);
      chk("deferred_pend", 32'(pend), 1);
      run_n(9, 0, c0, c1, cw);
      chk("deferred_pend_pos15", 32'(pend), 1);
      run_n(1, 0, c0, c1, cw);
      chk("deferred_pend_clear", 32'(pend), 0);
      run_n(16, 0, c0, c1, cw);
      chk("deferred_ch0_pulses", c0, 1);
      chk("deferred_ch1_pulses", c1, 16);
      step(0, 1, 1, 16'h0001, 1, 0, 0);
      chk("ld_e_no_pulse", 32'(en), 0);
      chk("ld_e_b0", 32'(b0), 1);
      run_n(20, 1, c0, c1, cw);
      chk("oneshot_advances", c1, 16);
      chk("oneshot_wraps", cw, 1);
      chk("oneshot_stopped", 32'(run), 0);
      chk("oneshot_en_idle", 32'(en), 0);
      step(0, 0, 1, 16'h0001, 1, 0, 0);
      chk("oneshot_restart", 32'(run), 1);
      run_n(18, 1, c0, c1, cw);
      chk("oneshot2_advances", c1, 16);
      step(0, 0, 1, 16'h0001, 0, 0, 0);
      run_n(15, 0, c0, c1, cw);
      step(0, 1, 0, 0, 0, 1, M_FREE);
      chk("wrap_write_pend", 32'(pend), 0);
      chk("wrap_write_pulse", 32'(wrap), 1);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      run_n(16, 0, c0, c1, cw);
      chk("wrap_write_ch0", c0, 6);
      step(0, 0, 1, 16'h0001, 0, 0, 0);
      run_n(9, 0, c0, c1, cw);
      step(0, 0, 0, 0, 0, 1, M_DEF);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("midrst_pend", 32'(pend), 0);
      chk("midrst_run", 32'(run), 1);
      chk("midrst_b0", 32'(b0), 1);
      run_n(16, 0, c0, c1, cw);
      chk("midrst_mask_default", c0 + c1, 0);
      chk("midrst_wrap", cw, 1);
      repeat (500) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 5,
              LEN'($urandom), $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
              {$urandom, $urandom});
      end
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/skipring_mc.md
# skipring_mc

Multi-channel, parametrised pulse-skipping ring. A LEN-bit selector pattern rotates one position per enabled cycle. Each of CH channels ANDs the current selector with its own LEN-bit skip mask and emits a registered clock-enable pulse. This yields CH independent fractional-rate enables from one clock, replacing gated derived clocks in the LED/clock-divider path. Mask updates are double-buffered and take effect only at ring wrap. An optional one-shot mode stops the ring after one revolution.

## Interface
- LEN, 16, ring length in bits; LEN >= 2.
- CH, 2, number of output channels; CH >= 1.
- defSEL, {{(LEN-1){1'b0}},1'b1}, selector value after reset.
- defMASK, 0 (CH*LEN bits), active mask value after reset.
- iCLK  in  1  sole clock; everything is synchronous to its rising edge.
- RST  in  1  synchronous, active-high reset.
- E  in  1  advance enable. Effective advance is `ADV = E & RUN & ~LD`.
- LD  in  1  load pulse: selector <= rSEL, position <= 0, RUN <= 1.
- rSEL  in  LEN  selector pattern for LD; any pattern is allowed, one-hot is not required.
- MODE  in  1  0 = free-running, 1 = one-shot (stop after a wrap).
- MASK_WR  in  1  write strobe for MASK into the shadow register.
- MASK  in  CH*LEN  channel c mask = MASK[c*LEN +: LEN].
- oEN  out  CH  registered per-channel enable pulses.
- oB0  out  1  selector bit 0, driven directly from the register.
- oWRAP  out  1  registered one-cycle pulse on each revolution end.
- oPEND  out  1  shadow mask is waiting for a wrap.
- oRUN  out  1  ring is running.

## Operation
- State:
  - SEL[LEN-1:0]
  - POS[$clog2(LEN)-1:0]
  - ACT[CH*LEN-1:0] (active masks)
  - SHD[CH*LEN-1:0] (shadow masks)
  - PEND
  - RUN
- Reset values: SEL=defSEL, POS=0, ACT=defMASK, SHD=0, PEND=0, RUN=1, oEN=0, oWRAP=0, oB0=defSEL[0].
- Advance (ADV=1):
  - Rotate left: SEL <= {SEL[LEN-2:0], SEL[LEN-1]}.
  - POS <= (POS==LEN-1) ? 0 : POS+1.
  - oEN[c] <= |(SEL & ACT[c]), using the pre-rotate SEL and current ACT.
- Wrap: WRAP = ADV & (POS==LEN-1).
  - oWRAP <= WRAP.
  - In MODE=1, WRAP clears RUN.
- No advance: oEN <= 0 and oWRAP <= 0. SEL and POS hold.
- LD has priority over E:
  - SEL <= rSEL, POS <= 0, RUN <= 1.
  - oEN <= 0, oWRAP <= 0.
- Mask staging:
  - MASK_WR alone: SHD <= MASK, PEND <= 1. A repeated write while PEND=1 overwrites SHD.
  - Transfer: when PEND & (WRAP | ~RUN), ACT <= SHD and PEND <= 0.
  - MASK_WR coinciding with a transfer condition: ACT <= MASK directly and PEND <= 0. The newest value wins.
- MODE changes take effect on the next wrap decision. Clearing MODE does not restart a stopped ring; only LD restarts it.
- RST wins over all other inputs, including mid-revolution and a pending mask. The pending mask is discarded.

## Timing
- Latency: the selector state seen at cycle N appears on oEN at cycle N+1. An ACT change applies to the first advance after the transfer edge.
- One revolution = LEN advances. Pulses per channel per revolution = popcount(ACT[c]) for a one-hot SEL.
- With E held high and MODE=0, the pattern repeats every LEN cycles.
- oWRAP is high for exactly one cycle per revolution. It coincides with the oEN of the POS=LEN-1 slot.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** RST=1 for 2 cycles, LEN=16, CH=2, defSEL=1 -> oEN=0, oWRAP=0, oB0=1, oRUN=1, oPEND=0.
- **Free-running pattern:**
  - Stimulus: MASK_WR with ch0 = 16'b0011010001000101, ch1 = 16'hFFFF, then E=1 continuously, MODE=0.
  - Transfer: ring is running, so ACT loads at the first wrap.
  - Required: over each following 16-cycle revolution, oEN[0] pulses 6 times, at slot positions 0, 2, 6, 10, 12 and 13. oEN[1] is high 16/16 cycles. oWRAP pulses once per revolution.
- **Deferred mask:**
  - Stimulus: MASK_WR with ch0 = 16'h0001 at POS=5.
  - Required: oPEND=1 until the POS=15 advance. The old mask pattern continues through slot 15. The new mask applies from slot 0, so oEN[0] gets exactly 1 pulse per revolution. oPEND then reads 0.
- **One-shot:**
  - Stimulus: MODE=1, LD with rSEL=16'h0001, E=1.
  - Required: exactly 16 advances, oWRAP once, then oRUN=0 and oEN stays 0. A second LD restarts it.
- **Simultaneous events:**
  - LD and E in the same cycle -> SEL=rSEL, POS=0, no oEN pulse.
  - MASK_WR on the wrap cycle -> ACT equals the written MASK and oPEND=0 next cycle.
  - E=0 -> all outputs hold, with oEN=0.
- **Reset mid-operation:** RST asserted at POS=9 with PEND=1 -> next cycle SEL=defSEL, POS=0, ACT=defMASK, oPEND=0, oRUN=1.
